// File: rtl/ser_to_par.sv
// ser_to_par -- serial-to-parallel deserializer.
//
// Consumes a one-bit valid/ready stream (LSB of each word first) and
// reassembles N-bit words, presenting them on a valid/ready parallel port
// through a one-word holding register. While a finished word waits in the
// holding register the next word keeps accumulating in the shift register;
// the serial side is only stalled when both are full.
//
// Optional feature macro: SER_TO_PAR_PARITY_EN
//   defined   : frames are N+1 bits, bit N is an even-parity bit and par_err
//               flags a parity mismatch for the word on par_data.
//   undefined : frames are N bits, no parity logic, no par_err port.
//
// Ports:
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset
//   ser_data   in   serial bit (LSB first)
//   ser_valid  in   ser_data is valid
//   ser_ready  out  block accepts a bit this cycle (decoded from state only)
//   par_data   out  [N-1:0] assembled word (holding register)
//   par_valid  out  par_data holds an undelivered word
//   par_ready  in   consumer accepts par_data this cycle
//   par_err    out  parity error for par_data (SER_TO_PAR_PARITY_EN only)

module ser_to_par #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         ser_data,
   input  logic         ser_valid,
   output logic         ser_ready,
   output logic [N-1:0] par_data,
   output logic         par_valid,
`ifdef SER_TO_PAR_PARITY_EN
   output logic         par_err,
`endif
   input  logic         par_ready
);

`ifdef SER_TO_PAR_PARITY_EN
   localparam int F = N + 1;
`else
   localparam int F = N;
`endif
   localparam int CW = $clog2(N + 2);
   localparam logic [CW-1:0] LAST = CW'(F - 1);

   typedef enum logic {FILL, FULL} state_t;

   state_t        state, state_nxt;
   logic [F-1:0]  sh;
   logic [F-1:0]  sh_nxt;
   logic [F-1:0]  xfer_word;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          last_bit;
   logic          slot_free;
   logic          xfer;

   assign ser_ready = (state == FILL);
   assign accept    = ser_valid && ser_ready;
   assign last_bit  = accept && (cnt == LAST);
   assign slot_free = !par_valid || par_ready;
   assign sh_nxt    = {ser_data, sh[F-1:1]};

   always_comb begin
      state_nxt = state;
      xfer      = 1'b0;
      xfer_word = sh;
      case (state)
         FILL: begin
            if (last_bit) begin
               if (slot_free) begin
                  // Transfer straight from the shifter with the final bit included.
                  xfer      = 1'b1;
                  xfer_word = sh_nxt;
               end else begin
                  state_nxt = FULL;
               end
            end
         end
         FULL: begin
            // The shift register already holds the complete frame.
            if (slot_free) begin
               xfer      = 1'b1;
               xfer_word = sh;
               state_nxt = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // Shift register and bit counter. The counter may sit at F while in FULL;
   // it is cleared only by a transfer.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sh  <= '0;
         cnt <= '0;
      end else begin
         if (accept) begin
            sh <= sh_nxt;
         end
         if (xfer) begin
            cnt <= '0;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Output holding register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         par_data  <= '0;
         par_valid <= 1'b0;
      end else begin
         if (xfer) begin
            par_data  <= xfer_word[N-1:0];
            par_valid <= 1'b1;
         end else if (par_ready) begin
            par_valid <= 1'b0;
         end
      end
   end

`ifdef SER_TO_PAR_PARITY_EN
   // Even parity: XOR over all F bits is 0 for a good frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         par_err <= 1'b0;
      end else if (xfer) begin
         par_err <= ^xfer_word;
      end
   end
`endif

endmodule
